// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, bus widths, 4-4-4 colours.
// Latency: n/a (package only).
// Backpressure: n/a.
// Colour packing is {R[3:0], G[3:0], B[3:0]}.
package vga_pkg;

   localparam int RGB_W   = 12;
   localparam int COORD_W = 11;

   // 640x480@60 with a 25 MHz pixel clock.
   localparam int H_SYNC_DEF  = 96;
   localparam int H_BACK_DEF  = 48;
   localparam int H_DISP_DEF  = 640;
   localparam int H_FRONT_DEF = 16;
   localparam int V_SYNC_DEF  = 2;
   localparam int V_BACK_DEF  = 33;
   localparam int V_DISP_DEF  = 480;
   localparam int V_FRONT_DEF = 10;

   localparam logic [RGB_W-1:0] BLACK = 12'h000;
   localparam logic [RGB_W-1:0] WHITE = 12'hFFF;
   localparam logic [RGB_W-1:0] RED   = 12'hF00;
   localparam logic [RGB_W-1:0] GREEN = 12'h0F0;
   localparam logic [RGB_W-1:0] BLUE  = 12'h00F;

   // Force a colour to black outside the active window.
   function automatic logic [RGB_W-1:0] rgb_blank(input logic en, input logic [RGB_W-1:0] c);
      return en ? c : BLACK;
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter plus sync/active window decode.
// Latency: decodes are combinational from the registered count.
// Backpressure: none; advances whenever i_en is high.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (count -> 0)
//   i_en              advance the count this cycle
//   o_last            i_en && count == TOTAL-1 (wraps this cycle)
//   o_sync            count inside the sync pulse [0, SYNC)
//   o_active          count inside the display window [SYNC+BACK, SYNC+BACK+DISP)
//   o_pos             count - (SYNC+BACK); meaningful only while o_active
// Axis order is sync, back porch, display, front porch. TOTAL must not exceed 2047.
module vga_axis_cnt
   import vga_pkg::*;
#(
   parameter int SYNC  = H_SYNC_DEF,
   parameter int BACK  = H_BACK_DEF,
   parameter int DISP  = H_DISP_DEF,
   parameter int FRONT = H_FRONT_DEF
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   output logic               o_last,
   output logic               o_sync,
   output logic               o_active,
   output logic [COORD_W-1:0] o_pos
);

   localparam int TOTAL = SYNC + BACK + DISP + FRONT;
   localparam int START = SYNC + BACK;

   localparam logic [COORD_W-1:0] C_LAST  = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] C_START = COORD_W'(START);
   localparam logic [COORD_W-1:0] C_END   = COORD_W'(START + DISP);
   localparam logic [COORD_W-1:0] C_SYNC  = COORD_W'(SYNC);
   localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);

   logic [COORD_W-1:0] r_cnt;
   logic               w_at_last;

   assign w_at_last = (r_cnt == C_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_at_last ? '0 : r_cnt + C_ONE;
      end
   end

   assign o_last   = i_en && w_at_last;
   assign o_sync   = (r_cnt < C_SYNC);
   assign o_active = (r_cnt >= C_START) && (r_cnt < C_END);
   assign o_pos    = r_cnt - C_START;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, coordinate/data request, synced RGB output.
// Latency: coordinates + data_req 1 cycle after the counters; hs/vs/de/rgb 2 cycles.
// Backpressure: none; free-running raster, pixel_data must be valid combinationally.
//
// Ports:
//   vga_clk, vga_rst          pixel clock, synchronous active-high reset
//   pixel_data                colour for the current pixel_xpos/pixel_ypos
//   pixel_xpos, pixel_ypos    active-area coordinates (0 outside active area)
//   data_req                  coordinates valid, pixel_data sampled this cycle
//   h_disp, v_disp            constant display size
//   vga_hs, vga_vs            active-low syncs
//   vga_de, vga_rgb           active-video enable and blanked colour
//   frame_start               one-cycle pulse with pixel (0,0) on vga_rgb
//   frame_cnt                 8-bit frame counter (only with VGA_FRAME_CNT_EN)
// Optional feature macro: VGA_FRAME_CNT_EN.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_SYNC  = H_SYNC_DEF,
   parameter int H_BACK  = H_BACK_DEF,
   parameter int H_DISP  = H_DISP_DEF,
   parameter int H_FRONT = H_FRONT_DEF,
   parameter int V_SYNC  = V_SYNC_DEF,
   parameter int V_BACK  = V_BACK_DEF,
   parameter int V_DISP  = V_DISP_DEF,
   parameter int V_FRONT = V_FRONT_DEF
)(
   input  logic               vga_clk,
   input  logic               vga_rst,
   input  logic [RGB_W-1:0]   pixel_data,
   output logic [COORD_W-1:0] pixel_xpos,
   output logic [COORD_W-1:0] pixel_ypos,
   output logic               data_req,
   output logic [COORD_W-1:0] h_disp,
   output logic [COORD_W-1:0] v_disp,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               vga_de,
   output logic [RGB_W-1:0]   vga_rgb,
   output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
   ,output logic [7:0]        frame_cnt
`endif
);

   logic               w_h_last;
   logic               w_h_sync;
   logic               w_h_act;
   logic [COORD_W-1:0] w_h_pos;
   logic               w_v_last;
   logic               w_v_sync;
   logic               w_v_act;
   logic [COORD_W-1:0] w_v_pos;
   logic               w_act;

   // Stage-1 copies of the sync decodes, so hs/vs line up with de at stage 2.
   logic r_hsync_d1;
   logic r_vsync_d1;
   logic r_first_d1;

   vga_axis_cnt #(
      .SYNC  (H_SYNC),
      .BACK  (H_BACK),
      .DISP  (H_DISP),
      .FRONT (H_FRONT)
   ) u_h_cnt (
      .i_clk    (vga_clk),
      .i_rst    (vga_rst),
      .i_en     (1'b1),
      .o_last   (w_h_last),
      .o_sync   (w_h_sync),
      .o_active (w_h_act),
      .o_pos    (w_h_pos)
   );

   // Vertical axis steps once per line, on the horizontal wrap.
   vga_axis_cnt #(
      .SYNC  (V_SYNC),
      .BACK  (V_BACK),
      .DISP  (V_DISP),
      .FRONT (V_FRONT)
   ) u_v_cnt (
      .i_clk    (vga_clk),
      .i_rst    (vga_rst),
      .i_en     (w_h_last),
      .o_last   (w_v_last),
      .o_sync   (w_v_sync),
      .o_active (w_v_act),
      .o_pos    (w_v_pos)
   );

   assign w_act  = w_h_act && w_v_act;
   assign h_disp = COORD_W'(H_DISP);
   assign v_disp = COORD_W'(V_DISP);

   // Stage 1: request and coordinates, one cycle ahead of the display.
   always_ff @(posedge vga_clk) begin
      if (vga_rst) begin
         data_req   <= 1'b0;
         pixel_xpos <= '0;
         pixel_ypos <= '0;
         r_hsync_d1 <= 1'b0;
         r_vsync_d1 <= 1'b0;
         r_first_d1 <= 1'b0;
      end else begin
         data_req   <= w_act;
         pixel_xpos <= w_act ? w_h_pos : '0;
         pixel_ypos <= w_act ? w_v_pos : '0;
         r_hsync_d1 <= w_h_sync;
         r_vsync_d1 <= w_v_sync;
         r_first_d1 <= w_act && (w_h_pos == '0) && (w_v_pos == '0);
      end
   end

   // Stage 2: pins. Colour is captured while data_req is high, black otherwise.
   always_ff @(posedge vga_clk) begin
      if (vga_rst) begin
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_de      <= 1'b0;
         vga_rgb     <= BLACK;
         frame_start <= 1'b0;
      end else begin
         vga_hs      <= !r_hsync_d1;
         vga_vs      <= !r_vsync_d1;
         vga_de      <= data_req;
         vga_rgb     <= rgb_blank(data_req, pixel_data);
         frame_start <= r_first_d1;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   localparam logic [COORD_W-1:0] C_LAST_ROW = COORD_W'(V_DISP - 1);

   logic r_row_last_d1;
   logic r_row_last_d2;

   // Last display row flag, delayed alongside de so the falling edge of de
   // on that row marks the end of the frame.
   always_ff @(posedge vga_clk) begin
      if (vga_rst) begin
         r_row_last_d1 <= 1'b0;
         r_row_last_d2 <= 1'b0;
         frame_cnt     <= '0;
      end else begin
         r_row_last_d1 <= w_act && (w_v_pos == C_LAST_ROW);
         r_row_last_d2 <= r_row_last_d1;
         if (vga_de && !data_req && r_row_last_d2) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // Unused in this build option: vertical wrap is implied by the counter.
   logic w_unused_v_last;
   assign w_unused_v_last = w_v_last;
`else
   logic w_unused_v_last;
   assign w_unused_v_last = w_v_last;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (17 x 9, frame = 153 cycles).
// Horizontal: sync 4, back 3, display 8, front 2 -> active starts at h=7.
// Vertical:   sync 2, back 2, display 4, front 1 -> active starts at v=4.
// Cycle k = 0 is the first cycle after reset release (h_cnt = 0).
module tb_vga_timing_gen;

   localparam int HS = 4, HB = 3, HD = 8, HF = 2;
   localparam int VS = 2, VB = 2, VD = 4, VF = 1;

   logic        vga_clk = 1'b0;
   logic        vga_rst;
   logic [11:0] pixel_data;
   logic [10:0] pixel_xpos, pixel_ypos;
   logic        data_req;
   logic [10:0] h_disp, v_disp;
   logic        vga_hs, vga_vs, vga_de;
   logic [11:0] vga_rgb;
   logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0]  frame_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen #(
      .H_SYNC (HS), .H_BACK (HB), .H_DISP (HD), .H_FRONT (HF),
      .V_SYNC (VS), .V_BACK (VB), .V_DISP (VD), .V_FRONT (VF)
   ) dut (
      .vga_clk     (vga_clk),
      .vga_rst     (vga_rst),
      .pixel_data  (pixel_data),
      .pixel_xpos  (pixel_xpos),
      .pixel_ypos  (pixel_ypos),
      .data_req    (data_req),
      .h_disp      (h_disp),
      .v_disp      (v_disp),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_de      (vga_de),
      .vga_rgb     (vga_rgb),
      .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
      ,.frame_cnt  (frame_cnt)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Downstream colour stage: {row[3:0], col[7:0]} while requested, junk otherwise.
   task automatic drive_pixel();
      if (data_req) pixel_data = {pixel_ypos[3:0], pixel_xpos[7:0]};
      else          pixel_data = 12'hABC;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_hs"},   int'(vga_hs), 1);
      chk({tag, "_vs"},   int'(vga_vs), 1);
      chk({tag, "_de"},   int'(vga_de), 0);
      chk({tag, "_rgb"},  int'(vga_rgb), 0);
      chk({tag, "_req"},  int'(data_req), 0);
      chk({tag, "_xpos"}, int'(pixel_xpos), 0);
      chk({tag, "_ypos"}, int'(pixel_ypos), 0);
      chk({tag, "_fs"},   int'(frame_start), 0);
   endtask

   // Called at a falling edge with reset asserted; releases it and checks ncyc cycles.
   task automatic run_raster(input string tag, input int ncyc);
      int hs_low = 0, vs_low = 0, de_cnt = 0, req_cnt = 0, fs_win = 0, fs_all = 0;
      int lead_err = 0, coord_err = 0, blank_err = 0, rgb_err = 0, per_err = 0;
      int last_fall = -1, row = 0, col = 0;
      logic prev_req = 1'b0, prev_hs = 1'b1, prev_de = 1'b0;
      logic [11:0] exp_rgb;
      vga_rst = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         drive_pixel();
         // Directed points (hand-computed for the 17 x 9 raster).
         if (k == 1)   chk({tag, "_hs_k1"}, int'(vga_hs), 1);
         if (k == 2)   chk({tag, "_hs_k2"}, int'(vga_hs), 0);
         if (k == 2)   chk({tag, "_vs_k2"}, int'(vga_vs), 0);
         if (k == 5)   chk({tag, "_hs_k5"}, int'(vga_hs), 0);
         if (k == 6)   chk({tag, "_hs_k6"}, int'(vga_hs), 1);
         if (k == 19)  chk({tag, "_hs_k19"}, int'(vga_hs), 0);
         if (k == 35)  chk({tag, "_vs_k35"}, int'(vga_vs), 0);
         if (k == 36)  chk({tag, "_vs_k36"}, int'(vga_vs), 1);
         if (k == 69)  chk({tag, "_hs_k69"}, int'(vga_hs), 1);
         if (k == 70)  chk({tag, "_hs_k70"}, int'(vga_hs), 0);
         if (k == 75)  chk({tag, "_req_k75"}, int'(data_req), 0);
         if (k == 76) begin
            chk({tag, "_req_k76"}, int'(data_req), 1);
            chk({tag, "_x_k76"}, int'(pixel_xpos), 0);
            chk({tag, "_y_k76"}, int'(pixel_ypos), 0);
            chk({tag, "_de_k76"}, int'(vga_de), 0);
         end
         if (k == 77) begin
            chk({tag, "_de_k77"}, int'(vga_de), 1);
            chk({tag, "_fs_k77"}, int'(frame_start), 1);
            chk({tag, "_rgb_k77"}, int'(vga_rgb), 0);
         end
         if (k == 78) begin
            chk({tag, "_rgb_k78"}, int'(vga_rgb), 12'h001);
            chk({tag, "_fs_k78"}, int'(frame_start), 0);
         end
         if (k == 84)  chk({tag, "_rgb_k84"}, int'(vga_rgb), 12'h007);
         if (k == 85)  chk({tag, "_de_k85"}, int'(vga_de), 0);
         if (k == 134) begin
            chk({tag, "_req_k134"}, int'(data_req), 1);
            chk({tag, "_x_k134"}, int'(pixel_xpos), 7);
            chk({tag, "_y_k134"}, int'(pixel_ypos), 3);
         end
         if (k == 135) chk({tag, "_rgb_k135"}, int'(vga_rgb), 12'h307);
         if (k == 229) chk({tag, "_fs_k229"}, int'(frame_start), 0);
         if (k == 230) chk({tag, "_fs_k230"}, int'(frame_start), 1);

         // One full raster seen at stage 2: cycles 2..154.
         if (k >= 2 && k <= 154) begin
            if (!vga_hs) hs_low++;
            if (!vga_vs) vs_low++;
            if (vga_de) de_cnt++;
            if (data_req) req_cnt++;
            if (frame_start) fs_win++;
         end
         if (frame_start) fs_all++;
         if (prev_hs && !vga_hs) begin
            if (last_fall >= 0 && (k - last_fall) != HS + HB + HD + HF) per_err++;
            last_fall = k;
         end
         if (k >= 1 && vga_de != prev_req) lead_err++;
         if (!data_req && (pixel_xpos != 0 || pixel_ypos != 0)) coord_err++;
         if (!vga_de && vga_rgb != 12'h000) blank_err++;
         if (frame_start) begin
            row = 0;
            col = 0;
         end else if (prev_de && !vga_de) begin
            row++;
            col = 0;
         end
         if (vga_de) begin
            exp_rgb = {row[3:0], col[7:0]};
            if (vga_rgb != exp_rgb) rgb_err++;
            col++;
         end
         prev_req = data_req;
         prev_hs  = vga_hs;
         prev_de  = vga_de;
         @(negedge vga_clk);
      end
      chk({tag, "_hs_low_cycles"}, hs_low, 9 * HS);
      chk({tag, "_vs_low_cycles"}, vs_low, VS * 17);
      chk({tag, "_de_cycles"}, de_cnt, HD * VD);
      chk({tag, "_req_cycles"}, req_cnt, HD * VD);
      chk({tag, "_fs_per_frame"}, fs_win, 1);
      chk({tag, "_fs_total"}, fs_all, 2);
      chk({tag, "_hs_period_err"}, per_err, 0);
      chk({tag, "_req_lead_err"}, lead_err, 0);
      chk({tag, "_coord_idle_err"}, coord_err, 0);
      chk({tag, "_rgb_blank_err"}, blank_err, 0);
      chk({tag, "_rgb_value_err"}, rgb_err, 0);
   endtask

   initial begin
      bit found;
      vga_rst    = 1'b1;
      pixel_data = 12'hFFF;
      repeat (10) @(negedge vga_clk);
      chk_reset_state("rst");
      chk("h_disp", int'(h_disp), HD);
      chk("v_disp", int'(v_disp), VD);

      run_raster("run0", 241);

      // Abort mid-frame on row 2, pixel 5 with a single-cycle reset.
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         drive_pixel();
         if (data_req && pixel_ypos == 2 && pixel_xpos == 5) found = 1'b1;
         else @(negedge vga_clk);
      end
      chk("mid_found", int'(found), 1);
      chk("mid_de_before", int'(vga_de), 1);
      vga_rst    = 1'b1;
      pixel_data = 12'hFFF;
      @(negedge vga_clk);
      chk_reset_state("mid_rst");
      run_raster("run1", 241);

`ifdef VGA_FRAME_CNT_EN
      vga_rst    = 1'b1;
      pixel_data = 12'h000;
      @(negedge vga_clk);
      chk("fc_reset", int'(frame_cnt), 0);
      vga_rst = 1'b0;
      // Last de of frame f is at k = 135 + 153f; the count shows f+1 from k = 136 + 153f.
      for (int k = 0; k <= 140 + 153 * 256; k++) begin
         if (k == 135) chk("fc_k135", int'(frame_cnt), 0);
         if (k == 136) chk("fc_k136", int'(frame_cnt), 1);
         if (k >= 140 && (k - 140) % 153 == 0)
            chk("fc_frame", int'(frame_cnt), ((k - 140) / 153 + 1) % 256);
         @(negedge vga_clk);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
